// File: rtl/conv2d_row_pe_stream.sv
// Single-row 2D convolution PE: loads one kernel row from a broadcast weight
// stream, then slides it across a (optionally zero-padded) square feature map.
module conv2d_row_pe_stream #(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned DIM_WIDTH = 16,
  parameter int unsigned WT_DIM    = 3,
  parameter int unsigned SIGNED    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DIM_WIDTH-1:0] row_idx,
  input  logic [DIM_WIDTH-1:0] fm_dim,
  input  logic                 pad_en,
  input  logic [DWIDTH-1:0]    w_data,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [DWIDTH-1:0]    fm_data,
  input  logic                 fm_valid,
  output logic                 fm_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned PW  = 2 * DWIDTH;
  localparam int unsigned SW  = (ACC_WIDTH > PW) ? ACC_WIDTH : PW;
  localparam int unsigned CW  = DIM_WIDTH + 3;
  localparam int unsigned PAD = (WT_DIM - 1) / 2;

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

  state_t                          state;
  logic [DIM_WIDTH-1:0]            row_idx_q;
  logic [DIM_WIDTH-1:0]            fm_dim_q;
  logic                            pad_en_q;
  logic [WT_DIM-1:0][DWIDTH-1:0]   w;
  logic [WT_DIM-1:0][DWIDTH-1:0]   tap;
  logic [CW-1:0]                   m, n, x, y;

  logic [CW-1:0]                   p_side;
  logic                            p_nz, halo, emit, stall, advance, at_end, w_last;
  logic [DWIDTH-1:0]               inj;
  logic [WT_DIM-1:0][DWIDTH-1:0]   tap_nxt;
  logic [SW-1:0]                   sum;

  // Full-width product, extended to the summation width per signedness.
  function automatic logic [SW-1:0] mul_ext(input logic [DWIDTH-1:0] a,
                                            input logic [DWIDTH-1:0] b);
    logic [PW-1:0] ea, eb, p;
    ea = {{DWIDTH{(SIGNED != 0) && a[DWIDTH-1]}}, a};
    eb = {{DWIDTH{(SIGNED != 0) && b[DWIDTH-1]}}, b};
    p  = ea * eb;
    if (SIGNED != 0) mul_ext = SW'($signed(p));
    else             mul_ext = SW'(p);
  endfunction

  always_comb begin
    p_side  = CW'(fm_dim_q) + (pad_en_q ? CW'(2 * PAD) : CW'(0));
    p_nz    = (p_side != '0);
    halo    = pad_en_q && ((x < CW'(PAD)) || (x >= p_side - CW'(PAD)) ||
                           (y < CW'(PAD)) || (y >= p_side - CW'(PAD)));
    emit    = (x >= CW'(WT_DIM - 1)) && (y >= CW'(row_idx_q)) &&
              (y + CW'(WT_DIM) <= p_side + CW'(row_idx_q));
    stall   = emit && out_valid && !out_ready;
    advance = (state == STREAM) && p_nz && !stall && (halo || fm_valid);
    fm_ready = (state == STREAM) && p_nz && !halo && !stall;
    at_end  = (x == p_side - CW'(1)) && (y == p_side - CW'(1));
    w_last  = (m == CW'(WT_DIM - 1)) && (n == CW'(WT_DIM - 1));
    inj     = halo ? '0 : fm_data;
    tap_nxt = '0;
    tap_nxt[0] = inj;
    for (int unsigned k = 1; k < WT_DIM; k++) tap_nxt[k] = tap[k-1];
    // Newest tap pairs with the last weight of the row.
    sum = '0;
    for (int unsigned k = 0; k < WT_DIM; k++) sum = sum + mul_ext(tap_nxt[k], w[WT_DIM-1-k]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      row_idx_q <= '0;
      fm_dim_q  <= '0;
      pad_en_q  <= 1'b0;
      w         <= '0;
      tap       <= '0;
      m         <= '0;
      n         <= '0;
      x         <= '0;
      y         <= '0;
      w_ready   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      // A new load overrides the clear, giving back-to-back results.
      if (advance) begin
        tap <= tap_nxt;
        if (emit) begin
          out_data  <= ACC_WIDTH'(sum);
          out_valid <= 1'b1;
        end
        if (x == p_side - CW'(1)) begin
          x <= '0;
          y <= y + CW'(1);
        end else begin
          x <= x + CW'(1);
        end
      end
      case (state)
        IDLE: begin
          if (start) begin
            row_idx_q <= row_idx;
            fm_dim_q  <= fm_dim;
            pad_en_q  <= pad_en;
            w         <= '0;
            tap       <= '0;
            m         <= '0;
            n         <= '0;
            x         <= '0;
            y         <= '0;
            w_ready   <= 1'b1;
            busy      <= 1'b1;
            state     <= LOAD_W;
          end
        end
        LOAD_W: begin
          if (w_valid) begin
            for (int unsigned k = 0; k < WT_DIM; k++)
              if ((m == CW'(row_idx_q)) && (n == CW'(k))) w[k] <= w_data;
            if (n == CW'(WT_DIM - 1)) begin
              n <= '0;
              m <= m + CW'(1);
            end else begin
              n <= n + CW'(1);
            end
            if (w_last) begin
              w_ready <= 1'b0;
              x       <= '0;
              y       <= '0;
              state   <= STREAM;
            end
          end
        end
        STREAM: begin
          if (!p_nz || (advance && at_end)) state <= DRAIN;
        end
        DRAIN: begin
          if (!out_valid) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_row_pe_stream.sv
// Bench for conv2d_row_pe_stream: a 32-bit unsigned and a 16-bit signed instance
// share stimulus; outputs are compared with a padded-grid reference model.
module tb_conv2d_row_pe_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] row_idx, fm_dim;
  logic        pad_en;
  logic [31:0] w_data, fm_data;
  logic        w_valid, fm_valid, out_ready;

  logic        w_ready0, fm_ready0, out_valid0, busy0, done0;
  logic [31:0] out_data0;
  logic        w_ready1, fm_ready1, out_valid1, busy1, done1;
  logic [31:0] out_data1;

  int tests = 0;
  int fails = 0;

  logic [31:0] wts [9];
  logic [31:0] fmq [$];
  logic [31:0] exp0 [$], exp1 [$], got0 [$], got1 [$];
  int          done0_cnt, done1_cnt;

  always #5 clk = ~clk;

  conv2d_row_pe_stream #(.DWIDTH(32), .ACC_WIDTH(32), .DIM_WIDTH(16), .WT_DIM(3), .SIGNED(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .row_idx(row_idx), .fm_dim(fm_dim), .pad_en(pad_en),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready0),
    .fm_data(fm_data), .fm_valid(fm_valid), .fm_ready(fm_ready0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .busy(busy0), .done(done0));

  conv2d_row_pe_stream #(.DWIDTH(16), .ACC_WIDTH(32), .DIM_WIDTH(16), .WT_DIM(3), .SIGNED(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .row_idx(row_idx), .fm_dim(fm_dim), .pad_en(pad_en),
    .w_data(w_data[15:0]), .w_valid(w_valid), .w_ready(w_ready1),
    .fm_data(fm_data[15:0]), .fm_valid(fm_valid), .fm_ready(fm_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .busy(busy1), .done(done1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ov0"}, 64'(out_valid0), 64'd0);
    check({tag, "_od0"}, 64'(out_data0),  64'd0);
    check({tag, "_wr0"}, 64'(w_ready0),   64'd0);
    check({tag, "_fr0"}, 64'(fm_ready0),  64'd0);
    check({tag, "_bz0"}, 64'(busy0),      64'd0);
    check({tag, "_dn0"}, 64'(done0),      64'd0);
    check({tag, "_ov1"}, 64'(out_valid1), 64'd0);
    check({tag, "_od1"}, 64'(out_data1),  64'd0);
    check({tag, "_wr1"}, 64'(w_ready1),   64'd0);
    check({tag, "_fr1"}, 64'(fm_ready1),  64'd0);
    check({tag, "_bz1"}, 64'(busy1),      64'd0);
    check({tag, "_dn1"}, 64'(done1),      64'd0);
  endtask

  // Value at padded-grid position (y,x); halo positions read as zero.
  function automatic logic [31:0] pix(input int y, input int x, input int n, input int pad, input int p);
    if (y < pad || y >= p - pad || x < pad || x >= p - pad) return 32'd0;
    return fmq[(y - pad) * n + (x - pad)];
  endfunction

  task automatic build_expected(input int n, input bit pe, input int ridx);
    int pad, p;
    longint s0, s1;
    logic [31:0] v, wv;
    pad = pe ? 1 : 0;
    p   = n + 2 * pad;
    exp0.delete();
    exp1.delete();
    for (int y = 0; y < p; y++) begin
      if (y >= ridx && y <= p - 3 + ridx) begin
        for (int x = 2; x < p; x++) begin
          s0 = 0;
          s1 = 0;
          for (int j = 0; j < 3; j++) begin
            v  = pix(y, x - 2 + j, n, pad, p);
            wv = (ridx < 3) ? wts[ridx * 3 + j] : 32'd0;
            s0 += longint'({32'd0, v}) * longint'({32'd0, wv});
            s1 += longint'($signed(v[15:0])) * longint'($signed(wv[15:0]));
          end
          exp0.push_back(s0[31:0]);
          exp1.push_back(s1[31:0]);
        end
      end
    end
  endtask

  task automatic run_job(input int n, input bit pe, input int ridx, input bit rnd,
                         input int hold, input int rst_after);
    int wi, fi, hold_left, post, fm_hs1, got_at_done;
    bit seen_first, wh, fh, prev_stall, aborted;
    logic [31:0] prev_data, tmp;
    build_expected(n, pe, ridx);
    got0.delete();
    got1.delete();
    done0_cnt = 0; done1_cnt = 0;
    wi = 0; fi = 0; hold_left = hold; post = -1; fm_hs1 = 0; got_at_done = -1;
    seen_first = 0; prev_stall = 0; aborted = 0; prev_data = '0;
    start = 1'b1; row_idx = 16'(ridx); fm_dim = 16'(n); pad_en = pe;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 3000 && post != 0; cyc++) begin
      w_valid   = (wi < 9) && (!rnd || $urandom_range(3) != 0);
      w_data    = (wi < 9) ? wts[wi] : $urandom();
      fm_valid  = (fi < fmq.size()) && (!rnd || $urandom_range(3) != 0);
      fm_data   = (fi < fmq.size()) ? fmq[fi] : $urandom();
      out_ready = rnd ? ($urandom_range(2) != 0) : (hold_left == 0);
      start     = rnd && (fi < fmq.size()) && ($urandom_range(1) == 1);
      if (rnd) begin
        row_idx = 16'($urandom());
        fm_dim  = 16'($urandom());
        pad_en  = 1'($urandom_range(1));
      end
      @(negedge clk);
      wh = w_valid && w_ready0;
      fh = fm_valid && fm_ready0;
      if (fm_valid && fm_ready1) fm_hs1++;
      if (out_valid0 && !seen_first) seen_first = 1;
      if (prev_stall && out_valid0) check("hold_stable", 64'(out_data0), 64'(prev_data));
      if (hold > 0 && seen_first && !out_ready) begin
        check("bp_data", 64'(out_data0), 64'(exp0[0]));
        check("bp_fm_ready", 64'(fm_ready0), 64'd0);
      end
      prev_stall = out_valid0 && !out_ready;
      prev_data  = out_data0;
      if (out_valid0 && out_ready) got0.push_back(out_data0);
      if (out_valid1 && out_ready) got1.push_back(out_data1);
      if (done0) begin
        done0_cnt++;
        if (got_at_done < 0) got_at_done = got0.size();
      end
      if (done1) done1_cnt++;
      if (post > 0) post--;
      else if (post < 0 && done0) post = 3;
      @(posedge clk); #1;
      wi += int'(wh);
      fi += int'(fh);
      if (seen_first && hold_left > 0) hold_left--;
      if (rst_after >= 0 && fi == rst_after) begin
        rst_n = 1'b0; w_valid = 1'b0; fm_valid = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("rst_mid");
        if (done0) done0_cnt++;
        aborted = 1;
        break;
      end
    end
    w_valid = 1'b0; fm_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
    if (aborted) begin
      check("rst_no_done", 64'(done0_cnt), 64'd0);
    end else begin
      check("done_cnt0", 64'(done0_cnt), 64'd1);
      check("done_cnt1", 64'(done1_cnt), 64'd1);
      check("outs_before_done", 64'(got_at_done), 64'(exp0.size()));
      check("fm_hs0", 64'(fi), 64'(n * n));
      check("fm_hs1", 64'(fm_hs1), 64'(n * n));
      check("n_out0", 64'(got0.size()), 64'(exp0.size()));
      check("n_out1", 64'(got1.size()), 64'(exp1.size()));
      for (int i = 0; i < exp0.size(); i++) begin
        tmp = 'x;
        if (i < got0.size()) tmp = got0[i];
        check("out0", 64'(tmp), 64'(exp0[i]));
        tmp = 'x;
        if (i < got1.size()) tmp = got1[i];
        check("out1", 64'(tmp), 64'(exp1[i]));
      end
    end
  endtask

  task automatic load_seq(input int n);
    for (int i = 0; i < 9; i++) wts[i] = 32'(i + 1);
    fmq.delete();
    for (int i = 0; i < n * n; i++) fmq.push_back(32'(i + 1));
  endtask

  task automatic load_rand(input int n);
    for (int i = 0; i < 9; i++) wts[i] = $urandom();
    fmq.delete();
    for (int i = 0; i < n * n; i++) fmq.push_back($urandom());
  endtask

  initial begin
    logic [31:0] g;
    int rn, rr;
    bit rp;
    rst_n = 1'b0; start = 1'b0; row_idx = '0; fm_dim = '0; pad_en = 1'b0;
    w_data = '0; fm_data = '0; w_valid = 1'b0; fm_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset");

    // Unsigned, no pad: 14, 20, 38, 44
    @(posedge clk); #1;
    load_seq(4);
    run_job(4, 0, 0, 0, 0, -1);
    g = 'x;
    if (got0.size() == 4) g = got0[3];
    check("s1_last", 64'(g), 64'd44);

    // Padded, row 1: 3, 3, 7, 7
    for (int i = 0; i < 9; i++) wts[i] = 32'd1;
    fmq.delete();
    for (int i = 0; i < 4; i++) fmq.push_back(32'(i + 1));
    run_job(2, 1, 1, 0, 0, -1);
    g = 'x;
    if (got0.size() > 2) g = got0[2];
    check("pad_third", 64'(g), 64'd7);

    // Backpressure: ready low 6 cycles after the first valid
    load_seq(4);
    run_job(4, 0, 0, 0, 6, -1);

    // Signed row 0: -2,1,0 against 3,-5,7
    load_rand(3);
    wts[0] = 32'hFFFF_FFFE; wts[1] = 32'd1; wts[2] = 32'd0;
    fmq[0] = 32'd3; fmq[1] = 32'hFFFF_FFFB; fmq[2] = 32'd7;
    run_job(3, 0, 0, 0, 0, -1);
    g = 'x;
    if (got1.size() > 0) g = got1[0];
    check("signed_first", 64'(g), 64'hFFFF_FFF5);

    // Too small for the kernel: no outputs
    load_rand(2);
    run_job(2, 0, 0, 0, 0, -1);

    // Row index outside the kernel: zero results, with start noise while busy
    load_rand(4);
    run_job(4, 1, 5, 1, 0, -1);

    // Reset after 5 fm handshakes, then a fresh identical job
    load_seq(4);
    run_job(4, 0, 0, 0, 0, 5);
    load_seq(4);
    run_job(4, 0, 0, 0, 0, -1);

    // Randomised jobs with gaps, backpressure and start noise
    for (int j = 0; j < 10; j++) begin
      rn = int'($urandom_range(0, 6));
      rp = 1'($urandom_range(1));
      rr = int'($urandom_range(0, 3));
      load_rand(rn);
      run_job(rn, rp, rr, 1, 0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv2d_row_pe_stream.md
Name: conv2d_row_pe_stream

Overview:
- Parametrised successor to the single-row 2D convolution processing element.
- Loads one row of a WT_DIM x WT_DIM kernel, selected by a runtime row index, from a broadcast weight stream.
- Streams a square feature map with optional zero padding, and emits one row-partial-sum per valid output position.
- New relative to the previous generation: valid/ready handshakes on all streams with output backpressure, a runtime padding enable, signed/unsigned mode, a separate accumulator width, and start/done job control.
- Sits between the accelerator's weight/feature-map readers and the row-sum adder/FIFO.

Parameters:
DWIDTH, 32, weight and feature-map word width
ACC_WIDTH, 32, result width; sums wrap modulo 2^ACC_WIDTH
DIM_WIDTH, 16, width of the fm_dim and row_idx fields
WT_DIM, 3, kernel dimension; odd, >= 1
SIGNED, 0, 1 = two's-complement multiply and accumulate; 0 = unsigned

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  job start; sampled only in IDLE
row_idx  in  DIM_WIDTH  kernel row owned by this PE; latched on start
fm_dim  in  DIM_WIDTH  feature-map side length N; latched on start
pad_en  in  1  1 = zero halo of width (WT_DIM-1)/2; latched on start
w_data  in  DWIDTH  weight word
w_valid  in  1  weight word valid
w_ready  out  1  PE accepts weight
fm_data  in  DWIDTH  feature-map word, row-major
fm_valid  in  1  fm word valid
fm_ready  out  1  PE accepts fm word
out_data  out  ACC_WIDTH  row partial sum
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
busy  out  1  not IDLE
done  out  1  one-cycle pulse at job end

Behaviour:
- Reset: one clock, synchronous active-low (rst_n low at a clk edge). Applies in any state, including mid-job; aborts the job with no done pulse. State goes to IDLE. All outputs 0: w_ready, fm_ready, out_valid, out_data, busy, done. Weights, taps and counters cleared.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN.
- IDLE: start=1 latches row_idx, fm_dim and pad_en, zeroes all weights, then moves to LOAD_W. start is ignored in every other state.
- LOAD_W: w_ready=1. Weights arrive row-major as WT_DIM*WT_DIM words, tracked by counters m (row) and n (column). A word with m==row_idx is written to w[n]. The handshake on the last word (m=n=WT_DIM-1) moves the FSM to STREAM. If row_idx >= WT_DIM, no weight is captured and all results are 0.
- STREAM geometry:
  - pad = pad_en ? (WT_DIM-1)/2 : 0; padded side P = N + 2*pad.
  - Grid positions (y,x) run over 0..P-1, row-major.
  - A position is halo when pad_en=1 and x<pad, x>=P-pad, y<pad or y>=P-pad. A halo position injects 0 and consumes no fm word. Every other position consumes one fm word.
- STREAM window and results:
  - Each advance shifts the injected value into a WT_DIM-tap shift register. tap[0] is the newest value.
  - result = sum over k of tap[k]*w[WT_DIM-1-k]: w[0] multiplies the oldest tap, w[WT_DIM-1] the newest.
  - Products are full width (2*DWIDTH), signedness set by SIGNED. The sum is truncated to ACC_WIDTH.
  - emit is true when x >= WT_DIM-1, y >= row_idx and y <= P-WT_DIM+row_idx. This is output row y-row_idx, column x-WT_DIM+1. Output count per job is (P-WT_DIM+1)^2, or 0 if P < WT_DIM.
- Output register and backpressure:
  - An emitting advance loads out_data and sets out_valid in the cycle after the advance.
  - out_valid and out_data hold stable until out_valid & out_ready.
  - stall = emit & out_valid & ~out_ready. While stalled, no advance happens: fm_ready=0 and halo positions do not progress.
  - A handshake and a new load in the same cycle are legal and give back-to-back results.
- Advance condition: advance = STREAM & ~stall & (halo | fm_valid). fm_ready = STREAM & ~halo & ~stall.
- End of stream: the advance at (P-1,P-1) moves the FSM to DRAIN. If P==0, STREAM moves to DRAIN immediately.
- DRAIN: waits for out_valid==0 (held result consumed), then pulses done for one cycle and returns to IDLE.
- Throughput: 1 position per cycle when fm_valid=1 and out_ready=1.

Test Plan:
- Unsigned, no pad, all sums:
  - Setup: WT_DIM=3, SIGNED=0, N=4, pad_en=0, row_idx=0; weights 1..9; fm 1..16; out_ready=1.
  - Required: outputs 14, 20, 38, 44 in order, then done one cycle after the last output handshake.
- Padded, row 1:
  - Setup: pad_en=1, N=2, row_idx=1; weights all 1; fm 1,2,3,4.
  - Required: P=4; outputs 3, 3, 7, 7; exactly 4 fm handshakes.
- Backpressure:
  - Setup: first scenario with out_ready held 0 for 6 cycles after the first out_valid.
  - Required: out_data=14 stable; fm_ready=0 once the next emit is pending; no lost or duplicated results; final sequence 14, 20, 38, 44.
- Signed:
  - Setup: SIGNED=1, ACC_WIDTH=32, N=3, row_idx=0; row-0 weights -2,1,0; fm row 0 = 3,-5,7.
  - Required: first output -11 (0xFFFFFFF5).
- Boundaries:
  - N=2, pad_en=0: no outputs; all 4 fm words accepted; done pulses.
  - row_idx=5: all outputs 0.
  - start asserted while busy: ignored.
- Reset mid-STREAM:
  - Stimulus: rst_n low for 1 cycle after 5 fm handshakes.
  - Required: next cycle all outputs 0 and state IDLE; no done pulse; a fresh job reproduces scenario 1 exactly.
